// File: rtl/lab2_pkg.sv
// lab2_pkg: shared types and widths for the lab2 checker slice.
//   state_t             checker FSM states
//   DEFAULT_TRUTH_TABLE expected z per index x (bit i = f(x=i))
//   *_W                 index, table, error-count and sample-counter widths
package lab2_pkg;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned TBL_W = 8;
    localparam int unsigned ERR_W = 4;
    localparam int unsigned CNT_W = 8;

    localparam logic [TBL_W-1:0] DEFAULT_TRUTH_TABLE = 8'b00111001;
    localparam logic [ERR_W-1:0] ERR_MAX             = '1;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/lab2_delay_line.sv
// lab2_delay_line: DELAY-stage shift register for the 3-bit vector index.
//   clock  rising-edge clock
//   reset  synchronous active-high reset, clears every stage
//   x      index from the generator
//   x_d    x delayed by DELAY cycles (x itself when DELAY=0)
module lab2_delay_line
    import lab2_pkg::*;
#(
    parameter int unsigned DELAY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] x,
    output logic [IDX_W-1:0] x_d
);

    if (DELAY == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clock ^ reset;
        assign x_d            = x;
    end else begin : g_shift
        logic [IDX_W-1:0] stage [DELAY];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int unsigned i = 0; i < DELAY; i++) stage[i] <= '0;
            end else begin
                stage[0] <= x;
                for (int unsigned i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
            end
        end

        assign x_d = stage[DELAY-1];
    end

endmodule

// File: rtl/lab2_checker.sv
// lab2_checker: consumer of the lab2 generator's z stream. Compares z with
// TRUTH_TABLE over one sweep of PERIOD samples, rebuilds the observed table
// and counts mismatches.
//   clock, reset    rising-edge clock, synchronous active-high reset
//   start           begin a sweep (honoured in IDLE and DONE only)
//   x, z            generator index and its function output (z lags by DELAY)
//   busy            high while aligning or checking
//   error           one-cycle pulse per mismatching sample
//   err_count       saturating mismatch count for this sweep
//   captured_table  observed z per index (last sample wins)
//   known_mask      indices sampled this sweep
//   done, pass      results valid / sweep clean and complete
module lab2_checker
    import lab2_pkg::*;
#(
    parameter logic [TBL_W-1:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE,
    parameter int unsigned      PERIOD      = 10,
    parameter int unsigned      DELAY       = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] x,
    input  logic             z,
    output logic             busy,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic [TBL_W-1:0] captured_table,
    output logic [TBL_W-1:0] known_mask,
    output logic             done,
    output logic             pass
);

    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] ALIGN_LAST  = (DELAY > 0) ? CNT_W'(DELAY - 1) : '0;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] x_d;
    logic             mismatch;

    lab2_delay_line #(
        .DELAY (DELAY)
    ) u_delay (
        .clock (clock),
        .reset (reset),
        .x     (x),
        .x_d   (x_d)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = (DELAY > 0) ? ALIGN : CHECK;
            ALIGN:      if (count == ALIGN_LAST)  state_next = CHECK;
            CHECK:      if (count == PERIOD_LAST) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ALIGN) || (state == CHECK);
        done = (state == DONE);
    end

    // One counter serves both the align wait and the sample count: it
    // restarts from zero on every state change.
    always_ff @(posedge clock) begin
        if (reset)                                   count <= '0;
        else if (state_next != state)                count <= '0;
        else if ((state == ALIGN) || (state == CHECK)) count <= count + 1'b1;
    end

    assign mismatch = z ^ TRUTH_TABLE[x_d];

    always_ff @(posedge clock) begin
        if (reset) begin
            error          <= 1'b0;
            err_count      <= '0;
            captured_table <= '0;
            known_mask     <= '0;
        end else begin
            error <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count      <= '0;
                        captured_table <= '0;
                        known_mask     <= '0;
                    end
                end
                CHECK: begin
                    error               <= mismatch;
                    captured_table[x_d] <= z;
                    known_mask[x_d]     <= 1'b1;
                    if (mismatch && (err_count != ERR_MAX)) err_count <= err_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pass = done && (err_count == '0) && (known_mask == '1);

endmodule

// File: tb/tb_lab2_checker.sv
// tb_lab2_checker: table-driven bench for lab2_checker. Three instances
// cover DELAY=0/PERIOD=10, DELAY=2/PERIOD=10 and DELAY=0/PERIOD=20; all share
// the same x/z/start/reset stimulus and each row checks one of them.
module tb_lab2_checker;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] x     = '0;
    logic       z     = 1'b0;

    logic [2:0] busy_a, error_a, done_a, pass_a;
    logic [3:0] errc_a [3];
    logic [7:0] cap_a  [3];
    logic [7:0] mask_a [3];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    lab2_checker #(.TRUTH_TABLE(8'b00111001), .PERIOD(10), .DELAY(0)) u_d0 (
        .clock(clock), .reset(reset), .start(start), .x(x), .z(z),
        .busy(busy_a[0]), .error(error_a[0]), .err_count(errc_a[0]),
        .captured_table(cap_a[0]), .known_mask(mask_a[0]),
        .done(done_a[0]), .pass(pass_a[0]));

    lab2_checker #(.TRUTH_TABLE(8'b00111001), .PERIOD(10), .DELAY(2)) u_d2 (
        .clock(clock), .reset(reset), .start(start), .x(x), .z(z),
        .busy(busy_a[1]), .error(error_a[1]), .err_count(errc_a[1]),
        .captured_table(cap_a[1]), .known_mask(mask_a[1]),
        .done(done_a[1]), .pass(pass_a[1]));

    lab2_checker #(.TRUTH_TABLE(8'b00111001), .PERIOD(20), .DELAY(0)) u_p20 (
        .clock(clock), .reset(reset), .start(start), .x(x), .z(z),
        .busy(busy_a[2]), .error(error_a[2]), .err_count(errc_a[2]),
        .captured_table(cap_a[2]), .known_mask(mask_a[2]),
        .done(done_a[2]), .pass(pass_a[2]));

    typedef struct {
        string      name;
        int         inst;      // which instance is checked
        int         lag;       // cycles z trails x in the stimulus
        int         zmode;     // 0: f(x), 1: constant 1, 2: ~f(x)
        int         flip_at;   // sample whose z is inverted (-1: none)
        int         start_at;  // cycle with a stray start pulse (-1: none)
        bit         do_reset;
        int         e_cycles;  // edges from start release to done
        int         e_err;
        logic [7:0] e_cap;
        logic [7:0] e_mask;
        bit         e_pass;
        int         e_pulses;
        int         e_first;   // cycle of first error pulse (-1: none)
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic z_for(input int j, input vec_t v);
        logic [7:0] tt;
        logic       b;
        tt = 8'b00111001;
        case (v.zmode)
            1:       b = 1'b1;
            2:       b = ~tt[j % 8];
            default: b = tt[j % 8];
        endcase
        if (j == v.flip_at) b = ~b;
        return b;
    endfunction

    initial begin
        vec_t v;
        int   cycles, pulses, first;

        //          name               inst lag zm flip st  rst cyc err cap    mask   pass pul first
        vecs[0] = '{"tt_d0",           0,   0,  0, -1,  -1, 1,  10, 0,  8'h39, 8'hFF, 1,   0,  -1};
        vecs[1] = '{"flip5",           0,   0,  0,  5,  -1, 1,  10, 1,  8'h19, 8'hFF, 0,   1,   5};
        vecs[2] = '{"ones",            0,   0,  1, -1,  -1, 1,  10, 5,  8'hFF, 8'hFF, 0,   5,   1};
        vecs[3] = '{"restart_in_done", 0,   0,  0, -1,  -1, 0,  10, 0,  8'h39, 8'hFF, 1,   0,  -1};
        vecs[4] = '{"saturate_p20",    2,   0,  2, -1,  -1, 1,  20, 15, 8'hC6, 8'hFF, 0,   20,  0};
        vecs[5] = '{"tt_d2",           1,   2,  0, -1,  -1, 1,  12, 0,  8'h39, 8'hFF, 1,   0,  -1};
        vecs[6] = '{"lag2_on_d0",      0,   2,  0, -1,  -1, 1,  10, 7,  8'hE4, 8'hFF, 0,   7,   0};
        vecs[7] = '{"start_in_check",  0,   0,  0, -1,   4, 1,  10, 0,  8'h39, 8'hFF, 1,   0,  -1};

        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_state_%0d", i),
                {busy_a[i], error_a[i], errc_a[i], cap_a[i], mask_a[i], done_a[i], pass_a[i]}, '0);
        end

        for (int r = 0; r < 8; r++) begin
            v = vecs[r];
            if (v.do_reset) do_reset();
            @(posedge clock); #1;
            start = 1'b1;
            x     = '0;
            z     = 1'b0;
            @(posedge clock); #1;
            start = 1'b0;
            chk({v.name, "/cleared"},
                {busy_a[v.inst], errc_a[v.inst], mask_a[v.inst]}, {1'b1, 4'd0, 8'd0});

            cycles = -1;
            pulses = 0;
            first  = -1;
            for (int k = 0; k < 100; k++) begin
                x     = 3'(k % 8);
                z     = (k >= v.lag) ? z_for(k - v.lag, v) : 1'b0;
                start = (k == v.start_at);
                @(posedge clock); #1;
                if (error_a[v.inst]) begin
                    pulses++;
                    if (first < 0) first = k;
                end
                if (done_a[v.inst]) begin
                    cycles = k + 1;
                    break;
                end
            end
            start = 1'b0;

            chk({v.name, "/cycles"},    cycles,             v.e_cycles);
            chk({v.name, "/busy_done"}, busy_a[v.inst],     1'b0);
            chk({v.name, "/err_count"}, errc_a[v.inst],     v.e_err);
            chk({v.name, "/captured"},  cap_a[v.inst],      v.e_cap);
            chk({v.name, "/known"},     mask_a[v.inst],     v.e_mask);
            chk({v.name, "/pass"},      pass_a[v.inst],     v.e_pass);
            chk({v.name, "/pulses"},    pulses,             v.e_pulses);
            if (v.e_first >= 0) chk({v.name, "/first_pulse"}, first, v.e_first);
        end

        // Reset in the middle of a failing sweep discards everything.
        do_reset();
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            x = 3'(k);
            z = ~z_for(k, vecs[0]);
            @(posedge clock); #1;
        end
        chk("mid_check_count", errc_a[0], 4'd4);
        chk("mid_check_busy",  busy_a[0], 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("mid_reset_outputs",
            {busy_a[0], error_a[0], errc_a[0], cap_a[0], mask_a[0], done_a[0], pass_a[0]}, '0);
        repeat (2) @(posedge clock);
        #1;
        chk("mid_reset_idle", {busy_a[0], done_a[0], mask_a[0]}, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
